// File: rtl/npc_pkg.sv
// Shared types and constants for the next-PC generator and its branch target buffer.
// Holds the nPC_sel encoding, counter states and the BTB entry layout.
package npc_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Wide enough for the smallest BTB (two entries); larger BTBs leave the top bits zero.
  typedef logic [29:0] btb_tag_t;

  typedef struct packed {
    logic        valid;
    btb_tag_t    tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  typedef enum logic [1:0] {
    BTB_ALLOC,
    BTB_UPDATE,
    BTB_INVAL
  } btb_wr_mode_e;

  function automatic btb_tag_t btb_tag(input logic [31:0] pc, input int unsigned idx_bits);
    return btb_tag_t'(pc >> (idx_bits + 2));
  endfunction

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/npc_bp_if.sv
// F-stage prediction outputs and D-stage resolve inputs of the next-PC generator.
// The slave side is the generator; the master side is the surrounding pipeline.
interface npc_bp_if;

  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic [31:0] pred_npc;
  logic        pred_taken;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_pred_npc;
  logic [1:0]  d_npc_sel;
  logic        d_cmp_taken;
  logic [25:0] d_imm26;
  logic [31:0] d_ext32;
  logic [31:0] d_rs;
  logic        flush_fd;
  logic [31:0] mispredict_cnt;

  modport slave (
    input  stall, d_valid, d_pc, d_pred_npc, d_npc_sel, d_cmp_taken, d_imm26, d_ext32, d_rs,
    output pc, pc_plus_4, pred_npc, pred_taken, flush_fd, mispredict_cnt
  );

  modport master (
    output stall, d_valid, d_pc, d_pred_npc, d_npc_sel, d_cmp_taken, d_imm26, d_ext32, d_rs,
    input  pc, pc_plus_4, pred_npc, pred_taken, flush_fd, mispredict_cnt
  );

endinterface

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer: combinational lookup by fetch PC, one synchronous
// write port whose update/invalidate modes are qualified by their own tag compare.
module npc_btb
  import npc_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  rd_pc,
  output logic         rd_taken,
  output logic [31:0]  rd_target,
  input  logic         wr_en,
  input  btb_wr_mode_e wr_mode,
  input  logic [31:0]  wr_pc,
  input  logic [31:0]  wr_target,
  input  logic [1:0]   wr_ctr,
  input  logic         wr_taken
);

  localparam int unsigned IDX = $clog2(ENTRIES);

  btb_entry_t     mem_q [ENTRIES];
  btb_entry_t     mem_d [ENTRIES];
  logic [IDX-1:0] rd_idx;
  logic [IDX-1:0] wr_idx;
  btb_tag_t       rd_tag;
  btb_tag_t       wr_tag;
  logic           wr_hit;

  assign rd_idx = rd_pc[IDX+1:2];
  assign wr_idx = wr_pc[IDX+1:2];
  assign rd_tag = btb_tag(rd_pc, IDX);
  assign wr_tag = btb_tag(wr_pc, IDX);

  // Lookup reads the registered array, so a same-cycle write is seen only from the next cycle.
  assign rd_taken  = mem_q[rd_idx].valid && (mem_q[rd_idx].tag == rd_tag) && mem_q[rd_idx].ctr[1];
  assign rd_target = mem_q[rd_idx].target;
  assign wr_hit    = mem_q[wr_idx].valid && (mem_q[wr_idx].tag == wr_tag);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      case (wr_mode)
        BTB_ALLOC: mem_d[wr_idx] = '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: wr_ctr};
        BTB_UPDATE: begin
          // A branch that misses only earns an entry once it has actually been taken.
          if (wr_hit) begin
            mem_d[wr_idx].target = wr_target;
            mem_d[wr_idx].ctr    = ctr_step(mem_q[wr_idx].ctr, wr_taken);
          end else if (wr_taken) begin
            mem_d[wr_idx] = '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: wr_ctr};
          end
        end
        BTB_INVAL: if (wr_hit) mem_d[wr_idx].valid = 1'b0;
        default: ;
      endcase
    end
  end

  // NOTE: this array is reset on purpose -- stale valid bits would predict garbage after
  // reset; plain data RAMs are normally left unreset so they can map onto memory macros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/npc_bp.sv
// F-stage next-PC generator: fetch PC register, BTB prediction, D-stage resolution
// with one-cycle redirect on mispredict, and a wrapping mispredict counter.
module npc_bp
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input logic     clk,
  input logic     rst_n,
  npc_bp_if.slave bus
);

  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  mispredict_cnt_q;
  logic [31:0]  mispredict_cnt_d;
  logic [31:0]  pred_npc;
  logic         btb_taken;
  logic [31:0]  btb_target;
  logic [31:0]  d_pc_plus_4;
  logic [31:0]  br_target;
  logic [31:0]  j_target;
  logic [31:0]  actual_npc;
  npc_sel_e     sel;
  logic         resolve;
  logic         mispredict;
  btb_wr_mode_e wr_mode;
  logic [31:0]  wr_target;
  logic [1:0]   wr_ctr;

  npc_btb #(
    .ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_pc    (pc_q),
    .rd_taken (btb_taken),
    .rd_target(btb_target),
    .wr_en    (resolve),
    .wr_mode  (wr_mode),
    .wr_pc    (bus.d_pc),
    .wr_target(wr_target),
    .wr_ctr   (wr_ctr),
    .wr_taken (bus.d_cmp_taken)
  );

  assign pred_npc = btb_taken ? btb_target : pc_q + 32'd4;

  assign sel         = npc_sel_e'(bus.d_npc_sel);
  assign d_pc_plus_4 = bus.d_pc + 32'd4;
  assign br_target   = d_pc_plus_4 + (bus.d_ext32 << 2);
  assign j_target    = {bus.d_pc[31:28], bus.d_imm26, 2'b00};

  // Branch entries always store the taken target, even when resolved not-taken.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    actual_npc = d_pc_plus_4;
    wr_mode    = BTB_INVAL;
    wr_target  = br_target;
    wr_ctr     = CTR_WT;
    case (sel)
      NPC_SEQ: ;
      NPC_BR: begin
        actual_npc = bus.d_cmp_taken ? br_target : d_pc_plus_4;
        wr_mode    = BTB_UPDATE;
      end
      NPC_J: begin
        actual_npc = j_target;
        wr_mode    = BTB_ALLOC;
        wr_target  = j_target;
        wr_ctr     = CTR_ST;
      end
      NPC_JR: actual_npc = bus.d_rs;
      default: ;
    endcase
  end

  // Gating with rst_n keeps flush_fd low while reset is held, whatever D presents.
  assign resolve    = rst_n && bus.d_valid && !bus.stall;
  assign mispredict = resolve && (actual_npc != bus.d_pred_npc);

  always_comb begin
    pc_d = pred_npc;
    if (mispredict)     pc_d = actual_npc;
    else if (bus.stall) pc_d = pc_q;
  end

  assign mispredict_cnt_d = mispredict_cnt_q + {31'd0, mispredict};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q             <= RESET_PC;
      mispredict_cnt_q <= '0;
    end else begin
      pc_q             <= pc_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc_plus_4      = pc_q + 32'd4;
  assign bus.pred_npc       = pred_npc;
  assign bus.pred_taken     = btb_taken;
  assign bus.flush_fd       = mispredict;
  assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_npc_bp.sv
// Self-checking bench for npc_bp: directed scenarios with literal expectations, then a
// randomized pipeline with a behavioural BTB/PC model compared every cycle.
module tb_npc_bp;
  import npc_pkg::*;

  localparam int          N    = 16;
  localparam int          IDXB = 4;
  localparam logic [31:0] RPC  = 32'h0000_3000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  npc_bp_if bus ();

  npc_bp #(
    .RESET_PC   (RPC),
    .BTB_ENTRIES(N)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: a direct-mapped table indexed by word address modulo N.
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_target[N];
  int          m_ctr   [N];
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  bit          last_mis;
  logic [31:0] last_fpc;
  logic [31:0] last_fpred;

  typedef struct packed {
    logic [1:0]  sel;
    logic [25:0] imm;
    logic [31:0] ext;
  } instr_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [31:0] p);
    return int'((p >> 2) % N);
  endfunction

  function automatic bit m_ptaken();
    int i = m_idx(m_pc);
    return m_valid[i] && (m_tag[i] == (m_pc >> (IDXB + 2))) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred();
    return m_ptaken() ? m_target[m_idx(m_pc)] : m_pc + 32'd4;
  endfunction

  function automatic logic [31:0] m_actual();
    case (bus.d_npc_sel)
      2'b00:   return bus.d_pc + 32'd4;
      2'b01:   return bus.d_cmp_taken ? bus.d_pc + 32'd4 + bus.d_ext32 * 32'd4 : bus.d_pc + 32'd4;
      2'b10:   return {bus.d_pc[31:28], bus.d_imm26, 2'b00};
      default: return bus.d_rs;
    endcase
  endfunction

  function automatic bit m_flush();
    return rst_n && bus.d_valid && !bus.stall && (m_actual() != bus.d_pred_npc);
  endfunction

  task automatic model_reset();
    m_pc  = RPC;
    m_cnt = 32'd0;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic model_step(output bit mis, output logic [31:0] f_pc, output logic [31:0] f_pred);
    logic [31:0] act  = m_actual();
    bit          res  = bus.d_valid && !bus.stall;
    int          i    = m_idx(bus.d_pc);
    logic [31:0] tag  = bus.d_pc >> (IDXB + 2);
    bit          hit  = m_valid[i] && (m_tag[i] == tag);
    logic [31:0] brt  = bus.d_pc + 32'd4 + bus.d_ext32 * 32'd4;
    mis    = res && (act != bus.d_pred_npc);
    f_pc   = m_pc;
    f_pred = m_pred();
    if (res) begin
      case (bus.d_npc_sel)
        2'b00: if (hit) m_valid[i] = 1'b0;
        2'b01: begin
          if (hit) begin
            m_target[i] = brt;
            if (bus.d_cmp_taken) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            else                 m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
          end else if (bus.d_cmp_taken) begin
            m_valid[i] = 1'b1; m_tag[i] = tag; m_target[i] = brt; m_ctr[i] = 2;
          end
        end
        2'b10: begin
          m_valid[i] = 1'b1; m_tag[i] = tag; m_target[i] = act; m_ctr[i] = 3;
        end
        default: if (hit) m_valid[i] = 1'b0;
      endcase
    end
    if (mis)             m_pc = act;
    else if (!bus.stall) m_pc = f_pred;
    if (mis) m_cnt = m_cnt + 32'd1;
  endtask

  task automatic compare_all();
    check("pc", bus.pc, m_pc);
    check("pc_plus_4", bus.pc_plus_4, m_pc + 32'd4);
    check("pred_npc", bus.pred_npc, m_pred());
    check("pred_taken", 32'(bus.pred_taken), 32'(m_ptaken()));
    check("flush_fd", 32'(bus.flush_fd), 32'(m_flush()));
    check("mispredict_cnt", bus.mispredict_cnt, m_cnt);
  endtask

  // One clock: compare settled outputs, advance the model on the edge, return at negedge.
  task automatic cyc();
    bit          mis = 1'b0;
    logic [31:0] fp  = 32'd0;
    logic [31:0] fpr = 32'd0;
    #1 compare_all();
    @(posedge clk);
    if (rst_n) model_step(mis, fp, fpr);
    else       model_reset();
    last_mis   = mis;
    last_fpc   = fp;
    last_fpred = fpr;
    @(negedge clk);
  endtask

  task automatic set_d(input bit v, input logic [31:0] p, input logic [31:0] pred,
                       input logic [1:0] sel, input bit tk, input logic [25:0] imm,
                       input logic [31:0] ext, input logic [31:0] rs);
    bus.d_valid     = v;
    bus.d_pc        = p;
    bus.d_pred_npc  = pred;
    bus.d_npc_sel   = sel;
    bus.d_cmp_taken = tk;
    bus.d_imm26     = imm;
    bus.d_ext32     = ext;
    bus.d_rs        = rs;
  endtask

  task automatic idle();
    set_d(1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 26'd0, 32'd0, 32'd0);
  endtask

  // Steer fetch with a jr from an otherwise unused PC; leaves D empty afterwards.
  task automatic redirect(input logic [31:0] target);
    set_d(1'b1, 32'h0000_5004, 32'h0000_5008, 2'b11, 1'b0, 26'd0, 32'd0, target);
    cyc();
    idle();
  endtask

  // Synthetic program over a 256-byte window; anything outside jumps back in.
  function automatic instr_t prog(input logic [31:0] p);
    logic [31:0] h = (p >> 2) * 32'h9E37_79B1;
    instr_t r;
    r.sel = 2'b00;
    r.imm = 26'h0000C00;
    r.ext = 32'd0;
    if (p < 32'h0000_3000 || p >= 32'h0000_3100) begin
      r.sel = 2'b10;
      r.imm = 26'h0000C00 + 26'((p >> 2) & 32'd63);
    end else begin
      case (h[31:28])
        4'd8, 4'd9, 4'd10, 4'd11: begin
          r.sel = 2'b01;
          r.ext = {{28{h[3]}}, h[3:0]};
        end
        4'd12, 4'd13: begin
          r.sel = 2'b10;
          r.imm = 26'h0000C00 + 26'(h[9:4]);
        end
        4'd14:   r.sel = 2'b11;
        default: r.sel = 2'b00;
      endcase
    end
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [31:0] hold;
    bit          fd_valid;
    logic [31:0] fd_pc, fd_pred, fd_rs;
    bit          fd_taken;
    instr_t      ins;
    bit          st;

    bus.stall = 1'b0;
    idle();
    #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset_pc", bus.pc, 32'h0000_3000);
    check("reset_pred_npc", bus.pred_npc, 32'h0000_3004);
    check("reset_pred_taken", 32'(bus.pred_taken), 32'd0);
    check("reset_flush", 32'(bus.flush_fd), 32'd0);
    check("reset_cnt", bus.mispredict_cnt, 32'd0);
    rst_n = 1'b1;

    cyc(); check("seq_pc_1", bus.pc, 32'h0000_3004);
    cyc(); check("seq_pc_2", bus.pc, 32'h0000_3008);
    bus.stall = 1'b1;
    cyc(); check("stall_hold_1", bus.pc, 32'h0000_3008);
    cyc(); check("stall_hold_2", bus.pc, 32'h0000_3008);
    bus.stall = 1'b0;
    cyc();
    cyc(); check("seq_pc_3010", bus.pc, 32'h0000_3010);
    set_d(1'b1, 32'h0000_300C, 32'h0000_3010, 2'b00, 1'b0, 26'd0, 32'd0, 32'd0);
    cyc();

    // beq at 3010, offset 4: first taken resolve mispredicts to 3024
    set_d(1'b1, 32'h0000_3010, 32'h0000_3014, 2'b01, 1'b1, 26'd0, 32'd4, 32'd0);
    #1 check("br1_flush", 32'(bus.flush_fd), 32'd1);
    cyc();
    check("br1_redirect_pc", bus.pc, 32'h0000_3024);
    check("br1_cnt", bus.mispredict_cnt, 32'd1);
    idle();
    redirect(32'h0000_3010);
    check("br2_pred_taken", 32'(bus.pred_taken), 32'd1);
    check("br2_pred_npc", bus.pred_npc, 32'h0000_3024);
    cyc();
    set_d(1'b1, 32'h0000_3010, 32'h0000_3024, 2'b01, 1'b1, 26'd0, 32'd4, 32'd0);
    #1 check("br2_no_flush", 32'(bus.flush_fd), 32'd0);
    cyc();
    check("br2_cnt", bus.mispredict_cnt, 32'd2);

    // two more taken (saturate at 11), then decay with not-taken resolves
    for (int k = 0; k < 2; k++) cyc();
    set_d(1'b1, 32'h0000_3010, 32'h0000_3024, 2'b01, 1'b0, 26'd0, 32'd4, 32'd0);
    #1 check("nt1_flush", 32'(bus.flush_fd), 32'd1);
    cyc();
    redirect(32'h0000_3010);
    check("ctr10_still_taken", bus.pred_npc, 32'h0000_3024);
    cyc();
    set_d(1'b1, 32'h0000_3010, 32'h0000_3024, 2'b01, 1'b0, 26'd0, 32'd4, 32'd0);
    cyc();
    redirect(32'h0000_3010);
    check("ctr01_pred_npc", bus.pred_npc, 32'h0000_3014);
    check("ctr01_pred_taken", 32'(bus.pred_taken), 32'd0);
    check("decay_cnt", bus.mispredict_cnt, 32'd6);

    // jal at 3020 to index 0C00 (address 3000)
    set_d(1'b1, 32'h0000_3020, 32'h0000_3024, 2'b10, 1'b0, 26'h0000C00, 32'd0, 32'd0);
    cyc();
    check("jal_redirect", bus.pc, 32'h0000_3000);
    redirect(32'h0000_3020);
    check("jal_pred_npc", bus.pred_npc, 32'h0000_3000);
    check("jal_pred_taken", 32'(bus.pred_taken), 32'd1);
    cyc();
    set_d(1'b1, 32'h0000_3020, 32'h0000_3000, 2'b10, 1'b0, 26'h0000C00, 32'd0, 32'd0);
    #1 check("jal_no_flush", 32'(bus.flush_fd), 32'd0);
    cyc();

    // jr from the same PC hits the jal entry: mispredict and invalidate
    set_d(1'b1, 32'h0000_3020, 32'h0000_3000, 2'b11, 1'b0, 26'd0, 32'd0, 32'h0000_4000);
    #1 check("jr_flush", 32'(bus.flush_fd), 32'd1);
    cyc();
    check("jr_redirect", bus.pc, 32'h0000_4000);
    redirect(32'h0000_3020);
    check("jr_inval_pred", bus.pred_npc, 32'h0000_3024);
    check("jr_inval_taken", 32'(bus.pred_taken), 32'd0);

    // would-be mispredict under stall does nothing
    bus.stall = 1'b1;
    set_d(1'b1, 32'h0000_3010, 32'h0000_3014, 2'b01, 1'b1, 26'd0, 32'd4, 32'd0);
    #1 check("stall_no_flush", 32'(bus.flush_fd), 32'd0);
    hold = m_pc;
    cyc();
    check("stall_no_redirect", bus.pc, hold);
    check("stall_cnt", bus.mispredict_cnt, 32'd10);
    bus.stall = 1'b0;
    idle();

    // same-index lookup and write in one cycle: F sees the old target
    set_d(1'b1, 32'h0000_3040, 32'h0000_3044, 2'b10, 1'b0, 26'h0000C20, 32'd0, 32'd0);
    cyc();
    redirect(32'h0000_3040);
    check("old_entry_pred", bus.pred_npc, 32'h0000_3080);
    set_d(1'b1, 32'h0000_3040, 32'h0000_30C0, 2'b10, 1'b0, 26'h0000C30, 32'd0, 32'd0);
    #1 check("same_idx_pred_old", bus.pred_npc, 32'h0000_3080);
    cyc();
    check("same_idx_pc", bus.pc, 32'h0000_3080);
    redirect(32'h0000_3040);
    check("new_entry_pred", bus.pred_npc, 32'h0000_30C0);

    // reset asserted in the middle of a redirect cycle
    set_d(1'b1, 32'h0000_3010, 32'h0000_3014, 2'b01, 1'b1, 26'd0, 32'd4, 32'd0);
    #1 check("pre_reset_flush", 32'(bus.flush_fd), 32'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset_pc", bus.pc, 32'h0000_3000);
    check("midreset_flush", 32'(bus.flush_fd), 32'd0);
    check("midreset_cnt", bus.mispredict_cnt, 32'd0);
    cyc();
    rst_n = 1'b1;
    idle();
    redirect(32'h0000_3040);
    check("post_reset_empty_a", bus.pred_npc, 32'h0000_3044);
    redirect(32'h0000_3010);
    check("post_reset_empty_b", bus.pred_npc, 32'h0000_3014);

    // randomized pipeline: F/D register emulated from the model's F-stage values
    fd_valid = 1'b0;
    fd_pc = 32'd0; fd_pred = 32'd0; fd_rs = 32'd0; fd_taken = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      st = ($urandom_range(0, 7) == 0);
      bus.stall = st;
      if (fd_valid) begin
        ins = prog(fd_pc);
        set_d(1'b1, fd_pc, fd_pred, ins.sel, fd_taken, ins.imm, ins.ext, fd_rs);
      end else begin
        set_d(1'b0, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              26'($urandom), $urandom, $urandom);
      end
      cyc();
      if (last_mis) begin
        fd_valid = 1'b0;
      end else if (!st) begin
        fd_valid = ($urandom_range(0, 15) != 0);
        fd_pc    = last_fpc;
        fd_pred  = ($urandom_range(0, 31) == 0) ? $urandom : last_fpred;
        fd_taken = ($urandom_range(0, 3) != 0);
        fd_rs    = 32'h0000_3000 + 32'($urandom_range(0, 63)) * 32'd4;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npc_bp.md
# npc_bp

Parametrised next-PC generator for the pipelined MIPS core, sitting in the F stage. It holds the fetch PC register and predicts the next fetch address through a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It resolves branch, j/jal and jr outcomes from the D stage and redirects fetch on mispredict. It supersedes the single-cycle combinational next-PC selector; the nPC_sel encoding is unchanged.

## Interface
- RESET_PC, 32'h0000_3000, fetch address after reset
- BTB_ENTRIES, 16, BTB depth; power of two, 2..256
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard-unit stall of F and D; holds the PC
- pc  out  32  current F-stage fetch address
- pc_plus_4  out  32  pc + 4
- pred_npc  out  32  predicted next PC for the F instruction; pipelined into D with it
- pred_taken  out  1  BTB hit with counter[1] = 1
- d_valid  in  1  D holds a real, non-bubble instruction
- d_pc  in  32  PC of the D instruction
- d_pred_npc  in  32  pred_npc that travelled with the D instruction
- d_npc_sel  in  2  00 sequential, 01 branch, 10 j/jal, 11 jr
- d_cmp_taken  in  1  branch comparator result
- d_imm26  in  26  jump index field
- d_ext32  in  32  sign-extended branch offset
- d_rs  in  32  forwarded rs value for jr
- flush_fd  out  1  kill the F/D register contents (mispredict)
- mispredict_cnt  out  32  count of mispredicts, wraps

## Operation
- Actual next PC for D is computed as follows:
  - sel 00: d_pc+4
  - sel 01: taken gives d_pc+4+(d_ext32<<2), not taken gives d_pc+4
  - sel 10: {d_pc[31:28], d_imm26, 2'b00}
  - sel 11: d_rs
- The design has no delay slots.
- The resolve event is d_valid & !stall. A mispredict is a resolve event where the actual next PC differs from d_pred_npc.
- flush_fd = mispredict, combinational.
- BTB lookup uses pc:
  - index = pc[IDX+1:2], tag = pc[31:IDX+2], where IDX = log2(BTB_ENTRIES)
  - each entry holds valid, tag, 32-bit target and a 2-bit counter
  - hit = valid && tag match
  - pred_npc = (hit && ctr[1]) ? target : pc+4
- BTB update happens only on a resolve event, and only for the d_pc index and tag:
  - branch, hit: target updated; counter increments (saturates at 11) if taken, decrements (saturates at 00) if not taken
  - branch, miss, taken: allocate, counter = 10
  - branch, miss, not taken: no write
  - j/jal: allocate or overwrite, counter = 11
  - jr: never allocated; a hit entry is invalidated
  - sequential with hit (alias or stale entry): invalidate
- PC update priority, highest first: mispredict gives pc <= actual next PC (overrides stall); otherwise stall holds pc; otherwise pc <= pred_npc.
- mispredict_cnt increments by 1 per mispredict and wraps from FFFF_FFFF to 0.

## Timing
- Reset (asynchronous, takes effect immediately and may occur mid-operation):
  - pc = RESET_PC
  - all BTB valid bits = 0; counters = 01
  - mispredict_cnt = 0
  - flush_fd = 0, pred_taken = 0, pred_npc = RESET_PC+4
- Lookup is combinational; the prediction is available in the same cycle as pc.
- Redirect latency is one cycle: mispredict in cycle N gives pc = target in N+1. The wrong-path F instruction is killed by flush_fd in cycle N.
- A BTB write at edge N is visible to a lookup from N+1. When F looks up the same index D writes in the same cycle, F sees the old entry.
- Nothing resolves while stall = 1: no BTB write, no counter change, no flush.
- Outputs other than pc and the registered state are combinational from state and inputs.

## Structure
- Package npc_pkg holds:
  - NPC_SEQ/NPC_BR/NPC_J/NPC_JR codes
  - default RESET_PC
  - a btb_entry_t struct (valid, tag, target, ctr)
  - counter constants CTR_SNT = 00 .. CTR_ST = 11
- One sub-module, npc_btb, contains the BTB storage:
  - one combinational read port keyed by pc
  - one synchronous write port with modes alloc / update / invalidate
  - asynchronous clear on rst_n
- Top level holds the PC register, actual-next-PC mux, mispredict compare and counter.

## Test plan
- Reset and sequential flow:
  - rst_n low then high, no D activity -> pc = 3000, 3004, 3008 on successive cycles
  - stall high for 2 cycles -> pc holds 3008
- Branch learning:
  - beq at 3010, offset 4, taken 3 times -> 1st resolve mispredicts (pred 3014, actual 3024), flush_fd = 1, pc = 3024 next cycle
  - 2nd resolve predicted correctly (pred_taken = 1 at pc 3010), no flush
  - mispredict_cnt = 1
- Counter saturation and decay:
  - the same branch taken ×4 then not taken ×2 -> counter 11, 10, 01
  - prediction flips to 3014 after the 2nd not-taken
- jal and jr:
  - jal at 3020 to index 0C00 -> 1 mispredict, then always predicted
  - jr to d_rs = 4000 whose PC aliases a BTB hit -> mispredict, pc = 4000, entry invalidated
- Simultaneous events:
  - mispredict asserted with stall = 1 is not a resolve event -> no redirect
  - same-index F lookup and D write -> F uses the old target
  - rst_n asserted mid-redirect -> pc = 3000 immediately; BTB empty afterwards
